// File: rtl/bru_pkg.sv
// -----------------------------------------------------------------------------
// bru_pkg
// Shared constants and helpers for the branch resolve unit:
//   - RV32 control-transfer opcodes and branch funct3 encodings
//   - 2-bit branch history counter encodings
//   - sat_inc / sat_dec saturating counter helpers
// -----------------------------------------------------------------------------
package bru_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,   // strongly not-taken
        CTR_WNT = 2'b01,   // weakly not-taken (reset value)
        CTR_WT  = 2'b10,   // weakly taken
        CTR_ST  = 2'b11    // strongly taken
    } ctr_e;

    // Increment a 2-bit counter, holding at strongly-taken.
    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        if (c == 2'b11) begin
            return 2'b11;
        end else begin
            return c + 2'd1;
        end
    endfunction

    // Decrement a 2-bit counter, holding at strongly-not-taken.
    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        if (c == 2'b00) begin
            return 2'b00;
        end else begin
            return c - 2'd1;
        end
    endfunction

endpackage

// File: rtl/bru_ras.sv
// -----------------------------------------------------------------------------
// bru_ras
// Circular return-address stack. Overflow wraps and overwrites the oldest
// entry; underflow wraps the pointer. A simultaneous pop and push behaves as
// pop followed by push (the top entry is replaced).
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   push         write push_data at ptr, ptr+1
//   pop          ptr-1
//   push_data    return address to push
//   top          entry[ptr-1]
// -----------------------------------------------------------------------------
module bru_ras #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);

    logic [XLEN-1:0]  stack_r [DEPTH];
    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] ptr_dec_s;
    logic [PTR_W-1:0] ptr_pop_s;
    logic [PTR_W-1:0] ptr_push_s;

    // Pointer arithmetic with explicit wrap so non-power-of-two depths work.
    always_comb begin
        ptr_dec_s  = (ptr_r == {PTR_W{1'b0}}) ? PTR_MAX : ptr_r - PTR_W'(1'b1);
        ptr_push_s = {PTR_W{1'b0}};
        if (pop) begin
            ptr_pop_s = ptr_dec_s;
        end else begin
            ptr_pop_s = ptr_r;
        end
        if (ptr_pop_s == PTR_MAX) begin
            ptr_push_s = {PTR_W{1'b0}};
        end else begin
            ptr_push_s = ptr_pop_s + PTR_W'(1'b1);
        end
    end

    // Stack storage and pointer update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r <= {PTR_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                stack_r[i] <= {XLEN{1'b0}};
            end
        end else if (push) begin
            stack_r[ptr_pop_s] <= push_data;
            ptr_r              <= ptr_push_s;
        end else begin
            ptr_r <= ptr_pop_s;
        end
    end

    assign top = stack_r[ptr_dec_s];

endmodule

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
// Resolves conditional branches, JAL and JALR in EX, produces a registered
// redirect/link result one cycle later, and maintains a BHT of 2-bit counters
// looked up combinationally by the fetch stage.
// Optional feature macro: BRU_RAS_EN (adds a return-address stack, bru_ras).
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   if_pc                 fetch PC for BHT lookup
//   if_pred_taken         counter bit[1] of the looked-up entry (combinational)
//   if_ras_target         RAS top (0 without BRU_RAS_EN)
//   ex_valid, ex_kill     EX instruction present / squashed
//   ex_opcode, ex_funct3  instruction decode fields
//   ex_rd, ex_rs1         register specifiers for RAS push/pop hints
//   ex_src_a, ex_src_b    operands
//   ex_imm, ex_pc         immediate and instruction PC
//   ex_pred_taken         prediction carried with the instruction
//   redirect_valid/pc     registered redirect to fetch
//   link_valid/data       registered link write (ex_pc+4)
//   mispredict_cnt        saturating redirect counter
// -----------------------------------------------------------------------------
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_IDX_W = 6,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    output logic [XLEN-1:0] if_ras_target,
    input  logic            ex_valid,
    input  logic            ex_kill,
    input  logic [6:0]      ex_opcode,
    input  logic [2:0]      ex_funct3,
    input  logic [4:0]      ex_rd,
    input  logic [4:0]      ex_rs1,
    input  logic [XLEN-1:0] ex_src_a,
    input  logic [XLEN-1:0] ex_src_b,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_pred_taken,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            link_valid,
    output logic [XLEN-1:0] link_data,
    output logic [15:0]     mispredict_cnt
);

    localparam int BHT_ENTRIES = 1 << BHT_IDX_W;

    logic [1:0]           bht_r [BHT_ENTRIES];
    logic [BHT_IDX_W-1:0] if_idx_s;
    logic [BHT_IDX_W-1:0] ex_idx_s;

    logic                 resolve_s;
    logic [XLEN-1:0]      pc_plus4_s;
    logic [XLEN-1:0]      br_target_s;
    logic [XLEN-1:0]      jalr_target_s;
    logic                 cmp_taken_s;
    logic                 cmp_legal_s;
    logic                 redirect_s;
    logic [XLEN-1:0]      redirect_pc_s;
    logic                 link_s;
    logic                 bht_we_s;
    logic                 ras_push_s;
    logic                 ras_pop_s;
    logic                 ras_hit_s;
    logic                 unused_s;

    assign if_idx_s      = if_pc[BHT_IDX_W+1:2];
    assign ex_idx_s      = ex_pc[BHT_IDX_W+1:2];
    assign if_pred_taken = bht_r[if_idx_s][1];
    assign resolve_s     = ex_valid && !ex_kill;

    assign pc_plus4_s    = ex_pc + XLEN'(3'd4);
    assign br_target_s   = ex_pc + ex_imm;
    assign jalr_target_s = (ex_src_a + ex_imm) & ~XLEN'(1'b1);

    // RAS hints: link registers x1/x5 mark calls (push) and returns (pop).
    assign ras_push_s = resolve_s && ((ex_opcode == OP_JAL) || (ex_opcode == OP_JALR)) &&
                        ((ex_rd == 5'd1) || (ex_rd == 5'd5));
    assign ras_pop_s  = resolve_s && (ex_opcode == OP_JALR) && (ex_rd == 5'd0) &&
                        ((ex_rs1 == 5'd1) || (ex_rs1 == 5'd5));

`ifdef BRU_RAS_EN
    logic [XLEN-1:0] ras_top_s;

    bru_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push_s),
        .pop       (ras_pop_s),
        .push_data (pc_plus4_s),
        .top       (ras_top_s)
    );

    // A return whose computed target matches the popped entry was already
    // fetched from the RAS prediction, so no redirect is needed.
    assign ras_hit_s     = ras_pop_s && (jalr_target_s == ras_top_s);
    assign if_ras_target = ras_top_s;
    assign unused_s      = ^{if_pc[1:0], if_pc[XLEN-1:BHT_IDX_W+2]};
`else
    assign ras_hit_s     = 1'b0;
    assign if_ras_target = {XLEN{1'b0}};
    assign unused_s      = ^{if_pc[1:0], if_pc[XLEN-1:BHT_IDX_W+2], ras_push_s, ras_pop_s};
`endif

    // Branch condition evaluation; funct3 010/011 are not valid branches.
    always_comb begin
        cmp_taken_s = 1'b0;
        cmp_legal_s = 1'b1;
        case (ex_funct3)
            F3_BEQ:  cmp_taken_s = (ex_src_a == ex_src_b);
            F3_BNE:  cmp_taken_s = (ex_src_a != ex_src_b);
            F3_BLT:  cmp_taken_s = ($signed(ex_src_a) <  $signed(ex_src_b));
            F3_BGE:  cmp_taken_s = ($signed(ex_src_a) >= $signed(ex_src_b));
            F3_BLTU: cmp_taken_s = (ex_src_a <  ex_src_b);
            F3_BGEU: cmp_taken_s = (ex_src_a >= ex_src_b);
            default: begin
                cmp_taken_s = 1'b0;
                cmp_legal_s = 1'b0;
            end
        endcase
    end

    // Resolve decision: redirect, target, link and BHT write enable.
    always_comb begin
        redirect_s    = 1'b0;
        redirect_pc_s = pc_plus4_s;
        link_s        = 1'b0;
        bht_we_s      = 1'b0;
        if (resolve_s) begin
            case (ex_opcode)
                OP_BRANCH: begin
                    redirect_s    = (cmp_taken_s != ex_pred_taken);
                    redirect_pc_s = cmp_taken_s ? br_target_s : pc_plus4_s;
                    bht_we_s      = cmp_legal_s;
                end
                OP_JAL: begin
                    redirect_s    = !ex_pred_taken;
                    redirect_pc_s = br_target_s;
                    link_s        = 1'b1;
                end
                OP_JALR: begin
                    redirect_s    = !ras_hit_s;
                    redirect_pc_s = jalr_target_s;
                    link_s        = 1'b1;
                end
                default: begin
                    redirect_s    = 1'b0;
                    redirect_pc_s = pc_plus4_s;
                    link_s        = 1'b0;
                    bht_we_s      = 1'b0;
                end
            endcase
        end else begin
            redirect_s    = 1'b0;
            redirect_pc_s = pc_plus4_s;
            link_s        = 1'b0;
            bht_we_s      = 1'b0;
        end
    end

    // BHT counters: reset to weakly not-taken, trained by resolved branches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_r[i] <= CTR_WNT;
            end
        end else if (bht_we_s) begin
            bht_r[ex_idx_s] <= cmp_taken_s ? sat_inc(bht_r[ex_idx_s]) : sat_dec(bht_r[ex_idx_s]);
        end else begin
            bht_r[ex_idx_s] <= bht_r[ex_idx_s];
        end
    end

    // Registered resolve results and saturating mispredict counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= {XLEN{1'b0}};
            link_valid     <= 1'b0;
            link_data      <= {XLEN{1'b0}};
            mispredict_cnt <= 16'd0;
        end else begin
            redirect_valid <= redirect_s;
            redirect_pc    <= redirect_s ? redirect_pc_s : {XLEN{1'b0}};
            link_valid     <= link_s;
            link_data      <= link_s ? pc_plus4_s : {XLEN{1'b0}};
            if (redirect_s && (mispredict_cnt != 16'hFFFF)) begin
                mispredict_cnt <= mispredict_cnt + 16'd1;
            end else begin
                mispredict_cnt <= mispredict_cnt;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
    import bru_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] if_ras_target;
    logic        ex_valid;
    logic        ex_kill;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic [4:0]  ex_rs1;
    logic [31:0] ex_src_a;
    logic [31:0] ex_src_b;
    logic [31:0] ex_imm;
    logic [31:0] ex_pc;
    logic        ex_pred_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        link_valid;
    logic [31:0] link_data;
    logic [15:0] mispredict_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    branch_resolve_unit #(.XLEN(32), .BHT_IDX_W(6), .RAS_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .if_ras_target(if_ras_target), .ex_valid(ex_valid), .ex_kill(ex_kill),
        .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_rd(ex_rd), .ex_rs1(ex_rs1),
        .ex_src_a(ex_src_a), .ex_src_b(ex_src_b), .ex_imm(ex_imm), .ex_pc(ex_pc),
        .ex_pred_taken(ex_pred_taken), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .link_valid(link_valid), .link_data(link_data),
        .mispredict_cnt(mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc,
                         input logic pred, input logic [4:0] rd, input logic [4:0] rs1);
        ex_valid = 1'b1; ex_kill = 1'b0; ex_opcode = op; ex_funct3 = f3;
        ex_src_a = a; ex_src_b = b; ex_imm = imm; ex_pc = pc;
        ex_pred_taken = pred; ex_rd = rd; ex_rs1 = rs1;
    endtask

    // Advance one edge, sample 1 time unit later, then idle the EX slot.
    task automatic step();
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        ex_kill  = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc);
        if_pc = pc;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ex_valid = 1'b0; ex_kill = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        vec_cnt++; if (redirect_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_redirect_valid got %0b want 0", redirect_valid); end
        vec_cnt++; if (redirect_pc !== 32'h0) begin err_cnt++; $display("FAIL reset_redirect_pc got %h want 0", redirect_pc); end
        vec_cnt++; if (link_valid !== 1'b0 || link_data !== 32'h0) begin err_cnt++; $display("FAIL reset_link got %0b/%h want 0/0", link_valid, link_data); end
        vec_cnt++; if (mispredict_cnt !== 16'd0) begin err_cnt++; $display("FAIL reset_cnt got %0d want 0", mispredict_cnt); end
        lookup(32'h0);
        vec_cnt++; if (if_pred_taken !== 1'b0) begin err_cnt++; $display("FAIL reset_pred got %0b want 0", if_pred_taken); end
        vec_cnt++; if (if_ras_target !== 32'h0) begin err_cnt++; $display("FAIL reset_ras got %h want 0", if_ras_target); end
    endtask

    task automatic test_beq();
        drive(OP_BRANCH, F3_BEQ, 32'd5, 32'd5, 32'h20, 32'h100, 1'b0, 5'd0, 5'd0);
        lookup(32'h100);
        vec_cnt++; if (if_pred_taken !== 1'b0) begin err_cnt++; $display("FAIL beq_nobypass got %0b want 0", if_pred_taken); end
        step();
        vec_cnt++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h120) begin err_cnt++; $display("FAIL beq_redirect got %0b/%h want 1/00000120", redirect_valid, redirect_pc); end
        vec_cnt++; if (link_valid !== 1'b0) begin err_cnt++; $display("FAIL beq_link got %0b want 0", link_valid); end
        vec_cnt++; if (if_pred_taken !== 1'b1) begin err_cnt++; $display("FAIL beq_bht got %0b want 1", if_pred_taken); end
        vec_cnt++; if (mispredict_cnt !== 16'd1) begin err_cnt++; $display("FAIL beq_cnt got %0d want 1", mispredict_cnt); end
        step();
        vec_cnt++; if (redirect_valid !== 1'b0) begin err_cnt++; $display("FAIL beq_one_cycle got %0b want 0", redirect_valid); end
    endtask

    task automatic test_signed_unsigned();
        drive(OP_BRANCH, F3_BLT, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h204, 1'b1, 5'd0, 5'd0);
        step();
        vec_cnt++; if (redirect_valid !== 1'b0) begin err_cnt++; $display("FAIL blt_signed got %0b want 0", redirect_valid); end
        drive(OP_BRANCH, F3_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h204, 1'b1, 5'd0, 5'd0);
        step();
        vec_cnt++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h208) begin err_cnt++; $display("FAIL bltu_unsigned got %0b/%h want 1/00000208", redirect_valid, redirect_pc); end
        drive(OP_BRANCH, F3_BGE, 32'h8000_0000, 32'd0, 32'h40, 32'h210, 1'b1, 5'd0, 5'd0);
        step();
        vec_cnt++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h214) begin err_cnt++; $display("FAIL bge_signed got %0b/%h want 1/00000214", redirect_valid, redirect_pc); end
        drive(OP_BRANCH, F3_BGEU, 32'h8000_0000, 32'd0, 32'h40, 32'h210, 1'b0, 5'd0, 5'd0);
        step();
        vec_cnt++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h250) begin err_cnt++; $display("FAIL bgeu_unsigned got %0b/%h want 1/00000250", redirect_valid, redirect_pc); end
        // illegal funct3: not-taken, no BHT update
        drive(OP_BRANCH, 3'b010, 32'd7, 32'd7, 32'h40, 32'h308, 1'b1, 5'd0, 5'd0);
        step();
        vec_cnt++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h30C) begin err_cnt++; $display("FAIL illegal_f3 got %0b/%h want 1/0000030c", redirect_valid, redirect_pc); end
        drive(OP_BRANCH, F3_BEQ, 32'd7, 32'd7, 32'h40, 32'h308, 1'b0, 5'd0, 5'd0);
        step();
        lookup(32'h308);
        vec_cnt++; if (if_pred_taken !== 1'b1) begin err_cnt++; $display("FAIL illegal_no_bht got %0b want 1", if_pred_taken); end
        vec_cnt++; if (mispredict_cnt !== 16'd6) begin err_cnt++; $display("FAIL signed_cnt got %0d want 6", mispredict_cnt); end
    endtask

    task automatic test_bht_saturate();
        logic exp_pred [6];
        exp_pred[0] = 1'b1; exp_pred[1] = 1'b1; exp_pred[2] = 1'b1; exp_pred[3] = 1'b1;
        exp_pred[4] = 1'b1; exp_pred[5] = 1'b0;
        lookup(32'h40);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive(OP_BRANCH, F3_BEQ, 32'd3, 32'd3, 32'h8, 32'h40, 1'b0, 5'd0, 5'd0);
            else       drive(OP_BRANCH, F3_BEQ, 32'd3, 32'd4, 32'h8, 32'h40, 1'b0, 5'd0, 5'd0);
            step();
            vec_cnt++; if (if_pred_taken !== exp_pred[i]) begin err_cnt++; $display("FAIL bht_sat_%0d got %0b want %0b", i, if_pred_taken, exp_pred[i]); end
        end
        vec_cnt++; if (mispredict_cnt !== 16'd10) begin err_cnt++; $display("FAIL bht_cnt got %0d want 10", mispredict_cnt); end
    endtask

    task automatic test_jumps();
        drive(OP_JALR, 3'b000, 32'h203, 32'h0, 32'h0, 32'h80, 1'b0, 5'd2, 5'd3);
        step();
        vec_cnt++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h202) begin err_cnt++; $display("FAIL jalr_redirect got %0b/%h want 1/00000202", redirect_valid, redirect_pc); end
        vec_cnt++; if (link_valid !== 1'b1 || link_data !== 32'h84) begin err_cnt++; $display("FAIL jalr_link got %0b/%h want 1/00000084", link_valid, link_data); end
        drive(OP_JAL, 3'b000, 32'h0, 32'h0, 32'hFFFF_FFF0, 32'h1000, 1'b0, 5'd2, 5'd0);
        step();
        vec_cnt++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'hFF0 || link_data !== 32'h1004) begin err_cnt++; $display("FAIL jal_neg got %0b/%h/%h want 1/00000ff0/00001004", redirect_valid, redirect_pc, link_data); end
        drive(OP_JAL, 3'b000, 32'h0, 32'h0, 32'h40, 32'h1000, 1'b1, 5'd2, 5'd0);
        step();
        vec_cnt++; if (redirect_valid !== 1'b0 || link_valid !== 1'b1) begin err_cnt++; $display("FAIL jal_hit got %0b/%0b want 0/1", redirect_valid, link_valid); end
        drive(OP_JAL, 3'b000, 32'h0, 32'h0, 32'h8, 32'hFFFF_FFFC, 1'b0, 5'd2, 5'd0);
        step();
        vec_cnt++; if (redirect_pc !== 32'h4 || link_valid !== 1'b1 || link_data !== 32'h0) begin err_cnt++; $display("FAIL jal_wrap got %h/%0b/%h want 00000004/1/00000000", redirect_pc, link_valid, link_data); end
        drive(7'b0110011, 3'b000, 32'h1, 32'h1, 32'h8, 32'h400, 1'b0, 5'd1, 5'd1);
        step();
        vec_cnt++; if (redirect_valid !== 1'b0 || link_valid !== 1'b0) begin err_cnt++; $display("FAIL other_op got %0b/%0b want 0/0", redirect_valid, link_valid); end
        vec_cnt++; if (mispredict_cnt !== 16'd13) begin err_cnt++; $display("FAIL jump_cnt got %0d want 13", mispredict_cnt); end
    endtask

    task automatic test_kill_and_reset();
        drive(OP_BRANCH, F3_BNE, 32'd1, 32'd2, 32'h10, 32'h50, 1'b0, 5'd0, 5'd0);
        ex_kill = 1'b1;
        step();
        lookup(32'h50);
        vec_cnt++; if (redirect_valid !== 1'b0) begin err_cnt++; $display("FAIL kill_redirect got %0b want 0", redirect_valid); end
        vec_cnt++; if (if_pred_taken !== 1'b0) begin err_cnt++; $display("FAIL kill_bht got %0b want 0", if_pred_taken); end
        vec_cnt++; if (mispredict_cnt !== 16'd13) begin err_cnt++; $display("FAIL kill_cnt got %0d want 13", mispredict_cnt); end
        drive(OP_BRANCH, F3_BEQ, 32'd9, 32'd9, 32'h10, 32'h60, 1'b0, 5'd0, 5'd0);
        step();
        vec_cnt++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h70) begin err_cnt++; $display("FAIL prereset_redirect got %0b/%h want 1/00000070", redirect_valid, redirect_pc); end
        drive(OP_BRANCH, F3_BEQ, 32'd9, 32'd9, 32'h10, 32'h60, 1'b0, 5'd0, 5'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        lookup(32'h60);
        vec_cnt++; if (redirect_valid !== 1'b0 || mispredict_cnt !== 16'd0) begin err_cnt++; $display("FAIL midreset got %0b/%0d want 0/0", redirect_valid, mispredict_cnt); end
        vec_cnt++; if (if_pred_taken !== 1'b0) begin err_cnt++; $display("FAIL midreset_bht got %0b want 0", if_pred_taken); end
    endtask

    task automatic test_ras();
`ifdef BRU_RAS_EN
        logic [31:0] exp_top [4];
        drive(OP_JAL, 3'b000, 32'h0, 32'h0, 32'h100, 32'h10, 1'b1, 5'd1, 5'd0);
        step();
        vec_cnt++; if (if_ras_target !== 32'h14) begin err_cnt++; $display("FAIL ras_push got %h want 00000014", if_ras_target); end
        drive(OP_JALR, 3'b000, 32'h14, 32'h0, 32'h0, 32'h110, 1'b0, 5'd0, 5'd1);
        step();
        vec_cnt++; if (redirect_valid !== 1'b0 || link_valid !== 1'b1) begin err_cnt++; $display("FAIL ras_pop_hit got %0b/%0b want 0/1", redirect_valid, link_valid); end
        for (int i = 1; i <= 5; i++) begin
            drive(OP_JAL, 3'b000, 32'h0, 32'h0, 32'h40, 32'(i * 32'h100), 1'b1, 5'd1, 5'd0);
            step();
        end
        vec_cnt++; if (if_ras_target !== 32'h504) begin err_cnt++; $display("FAIL ras_overflow got %h want 00000504", if_ras_target); end
        exp_top[0] = 32'h404; exp_top[1] = 32'h304; exp_top[2] = 32'h204; exp_top[3] = 32'h504;
        for (int i = 0; i < 4; i++) begin
            drive(OP_JALR, 3'b000, if_ras_target, 32'h0, 32'h0, 32'h900, 1'b0, 5'd0, 5'd5);
            step();
            vec_cnt++; if (if_ras_target !== exp_top[i] || redirect_valid !== 1'b0) begin err_cnt++; $display("FAIL ras_pop_%0d got %h/%0b want %h/0", i, if_ras_target, redirect_valid, exp_top[i]); end
        end
`else
        drive(OP_JALR, 3'b000, 32'h14, 32'h0, 32'h0, 32'h110, 1'b0, 5'd0, 5'd1);
        step();
        vec_cnt++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h14) begin err_cnt++; $display("FAIL noras_jalr got %0b/%h want 1/00000014", redirect_valid, redirect_pc); end
        vec_cnt++; if (if_ras_target !== 32'h0) begin err_cnt++; $display("FAIL noras_target got %h want 0", if_ras_target); end
`endif
    endtask

    initial begin
        if_pc = 32'h0; ex_valid = 1'b0; ex_kill = 1'b0; ex_opcode = 7'd0; ex_funct3 = 3'd0;
        ex_rd = 5'd0; ex_rs1 = 5'd0; ex_src_a = 32'h0; ex_src_b = 32'h0; ex_imm = 32'h0;
        ex_pc = 32'h0; ex_pred_taken = 1'b0; rst_n = 1'b0;
        test_reset();
        test_beq();
        test_signed_unsigned();
        test_bht_saturate();
        test_jumps();
        test_kill_and_reset();
        test_ras();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
